// File: rtl/outbuff_cntl_pkg.sv
// Shared parameters and types for the output-buffer controller slice.
// Holds the geometry of a parity result, the memory geometry and the FSM state type.
package outbuff_cntl_pkg;

   localparam int W                 = 8;
   localparam int M_MAX             = 4;
   localparam int M_W               = 3;
   localparam int PACKET_LENGTH     = 64;
   localparam int OUTBUF_MEM_ADDR_W = 8;

   localparam int W_IDX_W = $clog2(W);
   localparam int M_IDX_W = $clog2(M_MAX);

   // Free-count value of an empty ring: DEPTH expressed in the counter width.
   localparam logic [OUTBUF_MEM_ADDR_W:0] DEPTH_CNT = {1'b1, {OUTBUF_MEM_ADDR_W{1'b0}}};

   typedef enum logic {OB_IDLE, OB_WRITE} outbuff_state_t;

   function automatic logic mreg_legal(input logic [M_W-1:0] m);
      return (m != '0) && (m <= M_W'(M_MAX));
   endfunction

endpackage

// File: rtl/outbuff_free_tracker.sv
// Ring write pointer and free-word accounting for the output-buffer memory.
// Flags a host release that would push the free count beyond DEPTH.
module outbuff_free_tracker
   import outbuff_cntl_pkg::*;
(
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         eng_rstn,
   input  logic                         wr_accept,
   input  logic                         host_pkt_free,
   output logic [OUTBUF_MEM_ADDR_W-1:0] wr_ptr,
   output logic [OUTBUF_MEM_ADDR_W:0]   free_cnt,
   output logic                         overflow
);

   // A release coinciding with a write cancels out, so it can never overflow.
   assign overflow = host_pkt_free && !wr_accept && (free_cnt == DEPTH_CNT);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr   <= '0;
         free_cnt <= DEPTH_CNT;
      end else if (!eng_rstn) begin
         wr_ptr   <= '0;
         free_cnt <= DEPTH_CNT;
      end else begin
         if (wr_accept) begin
            wr_ptr <= wr_ptr + OUTBUF_MEM_ADDR_W'(1);
         end
         case ({wr_accept, host_pkt_free})
            2'b10:   free_cnt <= free_cnt - (OUTBUF_MEM_ADDR_W+1)'(1);
            2'b01:   if (!overflow) free_cnt <= free_cnt + (OUTBUF_MEM_ADDR_W+1)'(1);
            default: free_cnt <= free_cnt;
         endcase
      end
   end

endmodule

// File: rtl/outbuff_cntl.sv
// Output-buffer controller: captures an engine parity result and serialises it into the ring memory.
// Optional OUTBUFF_CNTL_STATS_EN adds saturating write and stall counters.
module outbuff_cntl
   import outbuff_cntl_pkg::*;
(
   input  logic                                          clk,
   input  logic                                          rstn,
   input  logic                                          eng_rstn,
   input  logic                                          cntrl_outbuff_wr_en,
   input  logic [M_W-1:0]                                MReg,
   input  logic [0:W-1][0:M_MAX-1][PACKET_LENGTH-1:0]    eng_outbuf_data,
   input  logic                                          eng_outbuf_data_val,
   output logic                                          outbuf_eng_rdy,
   output logic                                          outbuf_mem_wr_req,
   output logic [OUTBUF_MEM_ADDR_W-1:0]                  outbuf_mem_wr_addr,
   output logic [PACKET_LENGTH-1:0]                      outbuf_mem_wr_data,
   input  logic                                          outbuf_mem_wr_rdy,
   input  logic                                          host_pkt_free,
   output logic [OUTBUF_MEM_ADDR_W:0]                    outbuf_free_cnt,
   output logic                                          outbuf_res_done,
   output logic                                          outbuf_err,
   output outbuff_state_t                                outbuf_state
`ifdef OUTBUFF_CNTL_STATS_EN
   ,
   output logic [31:0]                                   outbuf_stat_wr_cnt,
   output logic [31:0]                                   outbuf_stat_stall_cnt
`endif
);

   // Handshakes: a transfer happens on a rising edge where valid/req and rdy are both high;
   // the offering side holds its payload stable until then, and rdy never depends on valid.

   outbuff_state_t state_q, state_d;

   logic [0:W-1][0:M_MAX-1][PACKET_LENGTH-1:0] staging_q;
   logic [M_IDX_W-1:0]                         m_last_q;
   logic [W_IDX_W-1:0]                         w_idx_q;
   logic [M_IDX_W-1:0]                         m_idx_q;
   logic                                       done_q;
   logic                                       err_q;

   logic                                       capture;
   logic                                       illegal;
   logic                                       accept;
   logic                                       last_accept;
   logic                                       overflow;
   logic [OUTBUF_MEM_ADDR_W-1:0]               wr_ptr;

   assign outbuf_eng_rdy     = (state_q == OB_IDLE) && cntrl_outbuff_wr_en && eng_rstn;
   assign outbuf_mem_wr_req  = (state_q == OB_WRITE) && eng_rstn && (outbuf_free_cnt != '0);
   assign outbuf_mem_wr_addr = wr_ptr;
   assign outbuf_mem_wr_data = (state_q == OB_WRITE) ? staging_q[w_idx_q][m_idx_q] : '0;
   assign outbuf_res_done    = done_q;
   assign outbuf_err         = err_q;
   assign outbuf_state       = state_q;
   assign accept             = outbuf_mem_wr_req && outbuf_mem_wr_rdy;

   always_comb begin
      state_d     = state_q;
      capture     = 1'b0;
      illegal     = 1'b0;
      last_accept = 1'b0;
      case (state_q)
         OB_IDLE: begin
            if (eng_outbuf_data_val && outbuf_eng_rdy) begin
               if (mreg_legal(MReg)) begin
                  capture = 1'b1;
                  state_d = OB_WRITE;
               end else begin
                  illegal = 1'b1;
               end
            end
         end
         OB_WRITE: begin
            if (accept && (w_idx_q == W_IDX_W'(W-1)) && (m_idx_q == m_last_q)) begin
               last_accept = 1'b1;
               state_d     = OB_IDLE;
            end
         end
         default: state_d = OB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= OB_IDLE;
      end else if (!eng_rstn) begin
         state_q <= OB_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Packets leave in [w][m] order with w running fastest.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         staging_q <= '0;
         m_last_q  <= '0;
         w_idx_q   <= '0;
         m_idx_q   <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else if (!eng_rstn) begin
         staging_q <= '0;
         m_last_q  <= '0;
         w_idx_q   <= '0;
         m_idx_q   <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         done_q <= last_accept;
         err_q  <= err_q || illegal || overflow;
         if (capture) begin
            staging_q <= eng_outbuf_data;
            m_last_q  <= M_IDX_W'(MReg - M_W'(1));
            w_idx_q   <= '0;
            m_idx_q   <= '0;
         end else if (accept) begin
            if (w_idx_q == W_IDX_W'(W-1)) begin
               w_idx_q <= '0;
               m_idx_q <= m_idx_q + M_IDX_W'(1);
            end else begin
               w_idx_q <= w_idx_q + W_IDX_W'(1);
            end
         end
      end
   end

   outbuff_free_tracker u_free_tracker (
      .clk           (clk),
      .rstn          (rstn),
      .eng_rstn      (eng_rstn),
      .wr_accept     (accept),
      .host_pkt_free (host_pkt_free),
      .wr_ptr        (wr_ptr),
      .free_cnt      (outbuf_free_cnt),
      .overflow      (overflow)
   );

`ifdef OUTBUFF_CNTL_STATS_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         outbuf_stat_wr_cnt    <= '0;
         outbuf_stat_stall_cnt <= '0;
      end else if (!eng_rstn) begin
         outbuf_stat_wr_cnt    <= '0;
         outbuf_stat_stall_cnt <= '0;
      end else begin
         if (accept && (outbuf_stat_wr_cnt != '1)) begin
            outbuf_stat_wr_cnt <= outbuf_stat_wr_cnt + 32'd1;
         end
         if ((state_q == OB_WRITE) && !accept && (outbuf_stat_stall_cnt != '1)) begin
            outbuf_stat_stall_cnt <= outbuf_stat_stall_cnt + 32'd1;
         end
      end
   end
`endif

endmodule
